// File: rtl/des_pkg.sv
// Shared helpers and DES permutation tables (0-based source bit indices,
// entry k selects the input bit feeding output bit k+1, MSB-first numbering).
package des_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  localparam int des_e_map [48] = '{
    31,  0,  1,  2,  3,  4,   3,  4,  5,  6,  7,  8,
     7,  8,  9, 10, 11, 12,  11, 12, 13, 14, 15, 16,
    15, 16, 17, 18, 19, 20,  19, 20, 21, 22, 23, 24,
    23, 24, 25, 26, 27, 28,  27, 28, 29, 30, 31,  0
  };

  localparam int des_p_map [32] = '{
    15,  6, 19, 20, 28, 11, 27, 16,  0, 14, 22, 25,  4, 17, 30,  9,
     1,  7, 23, 13, 31, 26,  2,  8, 18, 12, 29,  5, 21, 10,  3, 24
  };

  localparam int des_ip_map [64] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7,
    56, 48, 40, 32, 24, 16,  8,  0, 58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4, 62, 54, 46, 38, 30, 22, 14,  6
  };

  localparam int des_fp_map [64] = '{
    39,  7, 47, 15, 55, 23, 63, 31, 38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29, 36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27, 34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25, 32,  0, 40,  8, 48, 16, 56, 24
  };

endpackage

// File: rtl/perm_table_bank.sv
// Double-buffered mapping table: config writes land in shadow, commit copies
// shadow (including a same-cycle write) into the active table used by the datapath.
module perm_table_bank
  import des_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 48,
  localparam int SEL_W = clog2(IN_W),
  localparam int ADR_W = clog2(OUT_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [ADR_W-1:0]       cfg_addr,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic                   cfg_commit,
  output logic                   cfg_err,
  output logic [OUT_W*SEL_W-1:0] active_flat
);

  logic wr_ok;
  logic cfg_err_reg;

  // Widen by one bit so the bound itself is representable for power-of-two sizes.
  assign wr_ok = cfg_we
              && ({1'b0, cfg_addr} < (ADR_W+1)'(OUT_W))
              && ({1'b0, cfg_sel}  < (SEL_W+1)'(IN_W));

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_err_reg <= 1'b0;
    else        cfg_err_reg <= cfg_we && !wr_ok;
  end

  assign cfg_err = cfg_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_entry
      localparam logic [SEL_W-1:0] ident_sel = SEL_W'(gi % IN_W);
      logic [SEL_W-1:0] shadow_reg, shadow_next, active_reg;

      assign shadow_next = (wr_ok && (cfg_addr == ADR_W'(gi))) ? cfg_sel : shadow_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_reg <= ident_sel;
          active_reg <= ident_sel;
        end else begin
          shadow_reg <= shadow_next;
          if (cfg_commit) active_reg <= shadow_next;
        end
      end

      assign active_flat[gi*SEL_W +: SEL_W] = active_reg;
    end
  endgenerate

endmodule

// File: rtl/perm_stream_unit.sv
// Runtime-programmable bit permutation/expansion with a one-stage
// valid/ready output register.
module perm_stream_unit
  import des_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 48,
  localparam int SEL_W = clog2(IN_W),
  localparam int ADR_W = clog2(OUT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [ADR_W-1:0] cfg_addr,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic             cfg_commit,
  output logic             cfg_err
);

  logic [OUT_W*SEL_W-1:0] active_flat;
  logic [IN_W-1:0]        in_rev;
  logic [OUT_W-1:0]       perm_data;
  logic [OUT_W-1:0]       out_data_reg;
  logic                   out_valid_reg;
  logic                   xfer;

  perm_table_bank #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_sel     (cfg_sel),
    .cfg_commit  (cfg_commit),
    .cfg_err     (cfg_err),
    .active_flat (active_flat)
  );

  // in_rev[k] is input bit k+1 in MSB-first numbering.
  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_rev
      assign in_rev[gi] = in_data[IN_W-1-gi];
    end
    for (gi = 0; gi < OUT_W; gi++) begin : g_mux
      logic [SEL_W-1:0] sel;
      assign sel = active_flat[gi*SEL_W +: SEL_W];
      assign perm_data[OUT_W-1-gi] = in_rev[sel];
    end
  endgenerate

  assign in_ready = !out_valid_reg || out_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (xfer) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= perm_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_perm_stream_unit.sv
// Directed bench for perm_stream_unit (IN_W=32, OUT_W=48) with hand-computed results.
module tb_perm_stream_unit;
  import des_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [4:0]  cfg_sel;
  logic        cfg_commit;
  logic        cfg_err;

  int passed = 0;
  int total  = 0;

  perm_stream_unit #(.IN_W(32), .OUT_W(48)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_sel    (cfg_sel),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_e_shadow;
    for (int i = 0; i < 48; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 6'(i);
      cfg_sel  = 5'(des_e_map[i]);
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_data !== 48'h0) $display("FAIL reset_data got=%h exp=0", out_data); else passed++;
    total++; if (cfg_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", cfg_err); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else passed++;
    rst_n = 1'b1;
    tick();
    $display("reset: valid=%b data=%h err=%b ready=%b", out_valid, out_data, cfg_err, in_ready);
  endtask

  task automatic test_identity;
    out_ready = 1'b1;
    send_word(32'h0000_0001);
    total++; if (out_valid !== 1'b1) $display("FAIL ident_valid got=%b exp=1", out_valid); else passed++;
    total++; if (out_data !== 48'h0000_0001_0000) $display("FAIL ident_data got=%h exp=000000010000", out_data); else passed++;
    $display("identity: in=00000001 out=%h", out_data);
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL ident_drain got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_e_table;
    load_e_shadow();
    send_word(32'h0000_0001);
    total++; if (out_data !== 48'h0000_0001_0000) $display("FAIL shadow_only got=%h exp=000000010000", out_data); else passed++;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    send_word(32'h0000_0001);
    total++; if (out_data !== 48'h8000_0000_0002) $display("FAIL e_word0 got=%h exp=800000000002", out_data); else passed++;
    $display("e_table: in=00000001 out=%h", out_data);
    send_word(32'h8000_0000);
    total++; if (out_data !== 48'h4000_0000_0001) $display("FAIL e_word1 got=%h exp=400000000001", out_data); else passed++;
    $display("e_table: in=80000000 out=%h", out_data);
    tick();
  endtask

  task automatic test_commit_midstream;
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_sel = 5'd0;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_0001; cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    total++; if (out_data !== 48'h8000_0000_0002) $display("FAIL commit_old got=%h exp=800000000002", out_data); else passed++;
    $display("commit_mid: word0 out=%h", out_data);
    tick();
    in_valid = 1'b0;
    total++; if (out_data !== 48'h0000_0000_0002) $display("FAIL commit_new got=%h exp=000000000002", out_data); else passed++;
    $display("commit_mid: word1 out=%h", out_data);
    tick();
    // Same-cycle write and commit restores E entry 0 straight into active.
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_sel = 5'd31; cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    send_word(32'h0000_0001);
    total++; if (out_data !== 48'h8000_0000_0002) $display("FAIL write_through got=%h exp=800000000002", out_data); else passed++;
    $display("write_through: out=%h", out_data);
    tick();
  endtask

  task automatic test_illegal_write;
    cfg_we = 1'b1; cfg_addr = 6'd48; cfg_sel = 5'd0;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) $display("FAIL err_pulse got=%b exp=1", cfg_err); else passed++;
    tick();
    total++; if (cfg_err !== 1'b0) $display("FAIL err_len got=%b exp=0", cfg_err); else passed++;
    cfg_we = 1'b1; cfg_addr = 6'd63; cfg_sel = 5'd5;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b1) $display("FAIL err_pulse63 got=%b exp=1", cfg_err); else passed++;
    cfg_we = 1'b1; cfg_addr = 6'd47; cfg_sel = 5'd0;
    tick();
    cfg_we = 1'b0;
    total++; if (cfg_err !== 1'b0) $display("FAIL err_legal got=%b exp=0", cfg_err); else passed++;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    send_word(32'h8000_0000);
    total++; if (out_data !== 48'h4000_0000_0001) $display("FAIL err_keep got=%h exp=400000000001", out_data); else passed++;
    $display("illegal: err checked, mapping out=%h", out_data);
    tick();
  endtask

  task automatic test_backpressure;
    logic [31:0] w [4];
    logic [47:0] e [4];
    w = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002};
    e = '{48'h8000_0000_0002, 48'h4000_0000_0001, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0004};
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = w[0];
    tick();
    in_data = w[1];
    for (int c = 0; c < 3; c++) begin
      total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); else passed++;
      total++; if (out_data !== e[0]) $display("FAIL bp_hold_data c=%0d got=%h exp=%h", c, out_data, e[0]); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready c=%0d got=%b exp=0", c, in_ready); else passed++;
      $display("backpressure hold %0d: out=%h ready=%b", c, out_data, in_ready);
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release got=%b exp=1", in_ready); else passed++;
    for (int k = 1; k < 4; k++) begin
      in_data = w[k];
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== e[k]) $display("FAIL bp_word%0d got=%b/%h exp=1/%h", k, out_valid, out_data, e[k]); else passed++;
      $display("backpressure word %0d: out=%h", k, out_data);
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    send_word(32'h0000_0001);
    total++; if (out_valid !== 1'b1) $display("FAIL rstm_pre got=%b exp=1", out_valid); else passed++;
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    cfg_we = 1'b1; cfg_addr = 6'd48;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rstm_valid got=%b exp=0", out_valid); else passed++;
    total++; if (out_data !== 48'h0) $display("FAIL rstm_data got=%h exp=0", out_data); else passed++;
    total++; if (cfg_err !== 1'b0) $display("FAIL rstm_err got=%b exp=0", cfg_err); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rstm_ready got=%b exp=1", in_ready); else passed++;
    rst_n = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    tick();
    send_word(32'h0000_0001);
    total++; if (out_data !== 48'h0000_0001_0000) $display("FAIL rstm_ident got=%h exp=000000010000", out_data); else passed++;
    $display("reset_midflight: out after reset=%h", out_data);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_commit = 1'b0;
    test_reset();
    test_identity();
    test_e_table();
    test_commit_midstream();
    test_illegal_write();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
